matmul_nxn: RTL

MATMUL_NXN -- requirements
Module: matmul_nxn

---
 rtl/matmul_nxn_if.sv | 34 +++
 rtl/matmul_nxn.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/matmul_nxn_if.sv
// AXI-Lite control plus AXI-Stream data bundle for matmul_nxn.
// slave  : the matrix-multiply block (receives writes/reads, ss stream, drives sm stream)
// master : the driver side (CPU/DMA model or testbench)
interface matmul_nxn_if #(
  parameter int pDATA_WIDTH = 32,
  parameter int pADDR_WIDTH = 12
);
  logic                   awvalid, awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid, wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid, arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid, rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   ss_tvalid, ss_tready, ss_tlast;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   sm_tvalid, sm_tready, sm_tlast;
  logic [pDATA_WIDTH-1:0] sm_tdata;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tlast, ss_tdata, sm_tready,
    output awready, wready, arready, rvalid, rdata,
           ss_tready, sm_tvalid, sm_tlast, sm_tdata
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tlast, ss_tdata, sm_tready,
    input  awready, wready, arready, rvalid, rdata,
           ss_tready, sm_tvalid, sm_tlast, sm_tdata
  );
endinterface

// File: rtl/matmul_nxn.sv
// NxN unsigned matrix multiplier C = A*B (mod 2^pDATA_WIDTH).
// B is streamed in first (row-major, N*N elements), then A one row at a time;
// after each A row the N results of that C row are streamed out.
// Ports: axis_clk, axis_rst_n (async, active-low); bus (matmul_nxn_if.slave):
//   AXI-Lite CTRL/STATUS at 0x00 = {err, ap_idle, ap_done, ap_start},
//   ss_* input stream, sm_* output stream.
module matmul_nxn #(
  parameter int N           = 4,
  parameter int pDATA_WIDTH = 32,
  parameter int pADDR_WIDTH = 12
) (
  input  logic         axis_clk,
  input  logic         axis_rst_n,
  matmul_nxn_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam int BW = $clog2(N * N);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);
  localparam logic [BW-1:0] LAST_B   = BW'(N * N - 1);

  typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_A, COMPUTE, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   ap_start_q, ap_start_d, ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d, err_q, err_d;
  logic                   wr_rdy_q, wr_rdy_d;
  logic                   rvalid_q, rvalid_d, rd_ctrl_q, rd_ctrl_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [BW-1:0]          b_cnt_q, b_cnt_d;
  logic [CW-1:0]          a_col_q, a_col_d, c_col_q, c_col_d, row_q, row_d;
  logic                   drain_q, drain_d;
  logic [pDATA_WIDTH-1:0] b_q [N*N];
  logic [pDATA_WIDTH-1:0] b_d [N*N];
  logic [pDATA_WIDTH-1:0] a_q [N];
  logic [pDATA_WIDTH-1:0] a_d [N];
  logic                   sm_tvalid_q, sm_tvalid_d, sm_tlast_q, sm_tlast_d;
  logic [pDATA_WIDTH-1:0] sm_tdata_q, sm_tdata_d;

  logic                   ss_tready, ss_fire, wr_fire, rd_fire, out_free, last_a;
  logic [pDATA_WIDTH-1:0] status, c_val;
  logic                   unused_wdata;

  assign unused_wdata = ^bus.wdata[pDATA_WIDTH-1:1];

  assign status    = {{(pDATA_WIDTH-4){1'b0}}, err_q, ap_idle_q, ap_done_q, ap_start_q};
  assign ss_tready = (state_q == LOAD_B) || (state_q == LOAD_A);
  assign ss_fire   = bus.ss_tvalid && ss_tready;
  assign wr_fire   = bus.awvalid && bus.wvalid && wr_rdy_q;
  assign rd_fire   = bus.arvalid && !rvalid_q;
  assign out_free  = !sm_tvalid_q || bus.sm_tready;
  assign last_a    = (row_q == LAST_COL) && (a_col_q == LAST_COL);

  // Dot product of the stored A row with column c_col of B.
  always_comb begin
    c_val = '0;
    for (int unsigned k = 0; k < N; k++)
      c_val = c_val + a_q[CW'(k)] * b_q[BW'(k * N) + BW'(c_col_q)];
  end

  always_comb begin
    state_d     = state_q;
    ap_start_d  = ap_start_q;
    ap_done_d   = ap_done_q;
    ap_idle_d   = ap_idle_q;
    err_d       = err_q;
    wr_rdy_d    = bus.awvalid && bus.wvalid && !wr_rdy_q;
    rvalid_d    = rvalid_q;
    rd_ctrl_d   = rd_ctrl_q;
    rdata_d     = rdata_q;
    b_cnt_d     = b_cnt_q;
    a_col_d     = a_col_q;
    c_col_d     = c_col_q;
    row_d       = row_q;
    drain_d     = drain_q;
    b_d         = b_q;
    a_d         = a_q;
    sm_tvalid_d = sm_tvalid_q;
    sm_tlast_d  = sm_tlast_q;
    sm_tdata_d  = sm_tdata_q;

    if (wr_fire && (bus.awaddr == '0) && bus.wdata[0] && ap_idle_q) begin
      ap_start_d = 1'b1;
      ap_done_d  = 1'b0;
      err_d      = 1'b0;
    end

    if (rvalid_q && bus.rready) begin
      rvalid_d = 1'b0;
      if (rd_ctrl_q) ap_done_d = 1'b0;
    end
    if (rd_fire) begin
      rvalid_d  = 1'b1;
      rd_ctrl_d = (bus.araddr == '0);
      rdata_d   = (bus.araddr == '0) ? status : '0;
    end

    if (sm_tvalid_q && bus.sm_tready) begin
      sm_tvalid_d = 1'b0;
      sm_tlast_d  = 1'b0;
    end

    // FSM updates come last so they win over the register-write path.
    unique case (state_q)
      IDLE: if (ap_start_q) begin
        state_d    = LOAD_B;
        ap_start_d = 1'b0;
        ap_idle_d  = 1'b0;
      end
      LOAD_B: if (ss_fire) begin
        b_d[b_cnt_q] = bus.ss_tdata;
        if (b_cnt_q == LAST_B) begin
          b_cnt_d = '0;
          state_d = LOAD_A;
        end else b_cnt_d = b_cnt_q + 1'b1;
      end
      LOAD_A: if (ss_fire) begin
        a_d[a_col_q] = bus.ss_tdata;
        if (bus.ss_tlast != last_a) err_d = 1'b1;
        if (a_col_q == LAST_COL) begin
          a_col_d = '0;
          state_d = COMPUTE;
        end else a_col_d = a_col_q + 1'b1;
      end
      COMPUTE: begin
        // drain: the row's final result sits in the output register; wait for it to go.
        if (!drain_q) begin
          if (out_free) begin
            sm_tvalid_d = 1'b1;
            sm_tdata_d  = c_val;
            sm_tlast_d  = (row_q == LAST_COL) && (c_col_q == LAST_COL);
            if (c_col_q == LAST_COL) begin
              c_col_d = '0;
              drain_d = 1'b1;
            end else c_col_d = c_col_q + 1'b1;
          end
        end else if (bus.sm_tready) begin
          drain_d = 1'b0;
          if (row_q == LAST_COL) begin
            row_d   = '0;
            state_d = DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = LOAD_A;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        ap_done_d = 1'b1;
        ap_idle_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= IDLE;
      ap_start_q  <= 1'b0;
      ap_done_q   <= 1'b0;
      ap_idle_q   <= 1'b1;
      err_q       <= 1'b0;
      wr_rdy_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rd_ctrl_q   <= 1'b0;
      rdata_q     <= '0;
      b_cnt_q     <= '0;
      a_col_q     <= '0;
      c_col_q     <= '0;
      row_q       <= '0;
      drain_q     <= 1'b0;
      b_q         <= '{default: '0};
      a_q         <= '{default: '0};
      sm_tvalid_q <= 1'b0;
      sm_tlast_q  <= 1'b0;
      sm_tdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      ap_start_q  <= ap_start_d;
      ap_done_q   <= ap_done_d;
      ap_idle_q   <= ap_idle_d;
      err_q       <= err_d;
      wr_rdy_q    <= wr_rdy_d;
      rvalid_q    <= rvalid_d;
      rd_ctrl_q   <= rd_ctrl_d;
      rdata_q     <= rdata_d;
      b_cnt_q     <= b_cnt_d;
      a_col_q     <= a_col_d;
      c_col_q     <= c_col_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      b_q         <= b_d;
      a_q         <= a_d;
      sm_tvalid_q <= sm_tvalid_d;
      sm_tlast_q  <= sm_tlast_d;
      sm_tdata_q  <= sm_tdata_d;
    end
  end

  assign bus.awready   = wr_rdy_q;
  assign bus.wready    = wr_rdy_q;
  assign bus.arready   = !rvalid_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.ss_tready = ss_tready;
  assign bus.sm_tvalid = sm_tvalid_q;
  assign bus.sm_tlast  = sm_tlast_q;
  assign bus.sm_tdata  = sm_tdata_q;
endmodule
